register_file: RTL

Architectural register file with rename tags for the out-of-order core. It is the receiving end of the reorder buffer commit port: it consumes commit_flag/rd/Q/V to retire values and clear tags. It also records dispatcher rename allocations and answers the dispatcher's two-operand Q/V queries combinationally. On rollback it discards every pending rename tag.

---
 rtl/register_file_if.sv | 37 +++
 rtl/register_file.sv | 90 +++++++++
 2 files changed

// File: rtl/register_file_if.sv
// Dispatcher and ROB-commit side signals of the architectural register file.
// The master is the core (dispatcher/ROB); the slave is register_file.
interface register_file_if #(
    parameter int REG_POS_WIDTH = 5,
    parameter int ROB_ID_WIDTH  = 4,
    parameter int DATA_WIDTH    = 32
);
    logic                     rdy;
    logic                     rollback_flag;
    logic [REG_POS_WIDTH-1:0] rs1_from_dsp;
    logic [REG_POS_WIDTH-1:0] rs2_from_dsp;
    logic [ROB_ID_WIDTH-1:0]  Q1_to_dsp;
    logic [ROB_ID_WIDTH-1:0]  Q2_to_dsp;
    logic [DATA_WIDTH-1:0]    V1_to_dsp;
    logic [DATA_WIDTH-1:0]    V2_to_dsp;
    logic                     ena_from_dsp;
    logic [REG_POS_WIDTH-1:0] rd_from_dsp;
    logic [ROB_ID_WIDTH-1:0]  rob_id_from_dsp;
    logic                     commit_flag;
    logic [REG_POS_WIDTH-1:0] rd_from_rob;
    logic [ROB_ID_WIDTH-1:0]  Q_from_rob;
    logic [DATA_WIDTH-1:0]    V_from_rob;

    modport master (
        output rdy, rollback_flag, rs1_from_dsp, rs2_from_dsp,
               ena_from_dsp, rd_from_dsp, rob_id_from_dsp,
               commit_flag, rd_from_rob, Q_from_rob, V_from_rob,
        input  Q1_to_dsp, Q2_to_dsp, V1_to_dsp, V2_to_dsp
    );

    modport slave (
        input  rdy, rollback_flag, rs1_from_dsp, rs2_from_dsp,
               ena_from_dsp, rd_from_dsp, rob_id_from_dsp,
               commit_flag, rd_from_rob, Q_from_rob, V_from_rob,
        output Q1_to_dsp, Q2_to_dsp, V1_to_dsp, V2_to_dsp
    );
endinterface

// File: rtl/register_file.sv
// Architectural register file with rename tags (tag 0 = value valid, x0 hardwired to zero).
// Optional same-cycle commit forwarding to the operand reads: REGFILE_COMMIT_BYPASS_EN.
module register_file #(
    parameter int REG_COUNT     = 32,
    parameter int REG_POS_WIDTH = 5,
    parameter int ROB_ID_WIDTH  = 4,
    parameter int DATA_WIDTH    = 32
) (
    input  logic           clk,
    input  logic           rst,
    register_file_if.slave rf_bus
);
    logic [ROB_ID_WIDTH-1:0] r_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]   r_v [REG_COUNT];

    logic w_commit;
    logic w_commit_clears;
    logic w_rename;

    assign w_commit        = rf_bus.commit_flag && (rf_bus.rd_from_rob != '0);
    // Only the producer that still owns the register may clear its tag.
    assign w_commit_clears = w_commit && (r_q[rf_bus.rd_from_rob] == rf_bus.Q_from_rob);
    assign w_rename        = rf_bus.ena_from_dsp && (rf_bus.rd_from_dsp != '0) &&
                             !rf_bus.rollback_flag;

    // NOTE: sequential state uses non-blocking assignments only; the later
    // assignment to the same entry in this block (rename after commit) wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset explicitly because reads of any index must
            // return zero straight after reset; this keeps it out of RAM macros.
            for (int i = 0; i < REG_COUNT; i++) begin
                r_q[i] <= '0;
                r_v[i] <= '0;
            end
        end else if (rf_bus.rdy) begin
            if (w_commit) begin
                r_v[rf_bus.rd_from_rob] <= rf_bus.V_from_rob;
            end
            if (w_commit_clears) begin
                r_q[rf_bus.rd_from_rob] <= '0;
            end
            if (rf_bus.rollback_flag) begin
                for (int i = 0; i < REG_COUNT; i++) begin
                    r_q[i] <= '0;
                end
            end else if (w_rename) begin
                r_q[rf_bus.rd_from_dsp] <= rf_bus.rob_id_from_dsp;
            end
        end
    end

    logic [ROB_ID_WIDTH-1:0] w_q1;
    logic [ROB_ID_WIDTH-1:0] w_q2;
    logic [DATA_WIDTH-1:0]   w_v1;
    logic [DATA_WIDTH-1:0]   w_v2;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_q1 = '0;
        w_v1 = '0;
        w_q2 = '0;
        w_v2 = '0;
        if (rf_bus.rs1_from_dsp != '0) begin
            w_q1 = r_q[rf_bus.rs1_from_dsp];
            w_v1 = r_v[rf_bus.rs1_from_dsp];
        end
        if (rf_bus.rs2_from_dsp != '0) begin
            w_q2 = r_q[rf_bus.rs2_from_dsp];
            w_v2 = r_v[rf_bus.rs2_from_dsp];
        end
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (w_commit && !rf_bus.rollback_flag && (rf_bus.rd_from_rob == rf_bus.rs1_from_dsp) &&
            (r_q[rf_bus.rs1_from_dsp] == rf_bus.Q_from_rob)) begin
            w_q1 = '0;
            w_v1 = rf_bus.V_from_rob;
        end
        if (w_commit && !rf_bus.rollback_flag && (rf_bus.rd_from_rob == rf_bus.rs2_from_dsp) &&
            (r_q[rf_bus.rs2_from_dsp] == rf_bus.Q_from_rob)) begin
            w_q2 = '0;
            w_v2 = rf_bus.V_from_rob;
        end
`endif
    end

    assign rf_bus.Q1_to_dsp = w_q1;
    assign rf_bus.Q2_to_dsp = w_q2;
    assign rf_bus.V1_to_dsp = w_v1;
    assign rf_bus.V2_to_dsp = w_v2;
endmodule
